tbcc_encoder_p: RTL and testbench
=================================

# tbcc_encoder_p

Parametrised LTE rate-1/3 convolutional encoder (K=7, generators 133/171/165 octal) that reads DATA_W-bit words from an upstream show-ahead FIFO. It encodes a block of programmable length, in tail-biting or zero-start mode, and buffers the three systematic-free sub-block streams in an internal output FIFO for the downstream interleaver. It is the drop-in successor to the fixed 8-bit, two-length encoder behind the top-level skeleton.

## Interface
- DATA_W, 8, bits per input/output word; must be >= 6
- DEPTH, 1024, output buffer entries; must be a power of 2
- LEN_W, 10, width of block length in words
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- data_valid  in  1  start pulse; samples tail_byte, code_block_length, tb_mode
- tail_byte  in  DATA_W  last word of the block; low 6 bits seed tail-biting state
- code_block_length  in  LEN_W  block length in words
- tb_mode  in  1  1 = tail-biting, 0 = zero initial state
- blk_empty  in  1  upstream FIFO empty
- blk_data  in  DATA_W  upstream FIFO head word (show-ahead)
- blk_data_rdreq  out  1  pop upstream FIFO
- q0, q1, q2  out  DATA_W  output buffer head: d0/d1/d2 streams
- out_empty  out  1  output buffer empty
- out_usedw  out  $clog2(DEPTH)+1  output buffer occupancy
- rdreq_subblock  in  1  pop q0/q1/q2 together
- busy  out  1  block in progress
- computation_done  out  1  one-cycle pulse, block fully encoded

## Operation
- Bit order: bit DATA_W-1 of a word is first in time. Block bits are c_0..c_{N-1}, with N = DATA_W*code_block_length.
- Outputs for bit k: d0 = c_k^c_{k-2}^c_{k-3}^c_{k-5}^c_{k-6}; d1 = c_k^c_{k-1}^c_{k-2}^c_{k-3}^c_{k-6}; d2 = c_k^c_{k-1}^c_{k-2}^c_{k-4}^c_{k-6}.
- State register s[1..6] holds c_{k-1}..c_{k-6}.
- Initial state:
  - tb_mode=1: c_{-j} = tail_byte[j-1] for j = 1..6.
  - tb_mode=0: all zero.
- One full word is encoded per cycle by an unrolled DATA_W-step combinational network. Its d0/d1/d2 words are written to the output buffer as one 3*DATA_W entry.
- FSM IDLE -> ENCODE -> DONE -> IDLE:
  - IDLE: data_valid=1 latches the inputs, clears the word counter and loads the state. Goes to ENCODE, or to DONE if code_block_length=0.
  - ENCODE: blk_data_rdreq = !blk_empty && out_usedw<DEPTH && count<len. Each rdreq pushes the encoded word, advances the state and increments count. When count reaches len, go to DONE.
  - DONE: computation_done=1 for exactly one cycle, then IDLE.
- busy=1 in ENCODE and DONE.
- data_valid is ignored while busy.
- A new block may start while the output buffer still holds earlier data; blocks are concatenated.
- Output buffer behaviour:
  - rdreq_subblock is ignored when out_empty.
  - Simultaneous push and pop leaves out_usedw unchanged.
  - No push when out_usedw==DEPTH, even if a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH.
- Reset mid-block: FSM returns to IDLE, output buffer is emptied, the partial block is discarded, and the upstream FIFO is not touched.

## Timing
- Reset values: blk_data_rdreq=0, busy=0, computation_done=0, out_empty=1, out_usedw=0, q0/q1/q2=0.
- blk_data_rdreq is combinational from registered state and blk_empty/out_usedw. blk_data is consumed at the same edge.
- Latency: a word popped at edge t is visible on q0..q2 with out_empty=0 immediately after edge t.
- rdreq_subblock at edge t advances q0..q2 after edge t.
- computation_done is asserted in the cycle after the edge that consumed the last word.
- Throughput: one word per cycle when unstalled.
- Minimum block turnaround: len+2 cycles from the data_valid edge.

## Structure
- Package tbcc_pkg holds:
  - generator constants G0=7'o133, G1=7'o171, G2=7'o165
  - FSM state enum
  - function encode_word(state, word) returning {next_state, d0, d1, d2}
- Sub-module tbcc_out_fifo (width 3*DATA_W, depth DEPTH, show-ahead, usedw) holds the output buffer.
- The encoder core is the FSM plus the counter.

## Test plan
- Zero-start impulse: tb_mode=0, len=1, word 0x80 -> q0=0xB6, q1=0xF2, q2=0xEA; computation_done pulses once.
- Tail-biting impulse: tb_mode=1, len=1, word 0x01, tail 0x01 -> q0=0x6D, q1=0xE5, q2=0xD5.
- All ones: tb_mode=1, len=2, words 0xFF 0xFF, tail 0xFF -> two entries, all 0xFF, out_usedw=2.
- Backpressure with DEPTH=4, len=6, no rdreq_subblock:
  - exactly 4 pops, then rdreq held low, out_usedw=4, busy=1;
  - after popping 2 entries, 2 more words are read and done pulses.
- Upstream starvation: blk_empty toggled every other cycle, len=4 -> rdreq only when !blk_empty; outputs match a reference model.
- Control corner cases:
  - len=0 -> done pulse one cycle after start, no pops;
  - data_valid while busy is ignored;
  - reset asserted mid-block -> all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/tbcc_pkg.sv
// Shared constants, FSM states and the word-wide encoding function
// for the LTE K=7 rate-1/3 tail-biting convolutional encoder.
package tbcc_pkg;

    localparam logic [6:0] G0 = 7'o133;
    localparam logic [6:0] G1 = 7'o171;
    localparam logic [6:0] G2 = 7'o165;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENCODE,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [5:0]       st;
        logic [MAX_W-1:0] d0;
        logic [MAX_W-1:0] d1;
        logic [MAX_W-1:0] d2;
    } enc_t;

    // st[5] is c_{k-1} and st[0] is c_{k-6}, so {c_k, st} lines up with the
    // generator taps; the word occupies the low w bits, MSB first in time.
    function automatic enc_t encode_word(
        input logic [5:0]       st,
        input logic [MAX_W-1:0] word,
        input int               w
    );
        enc_t       r;
        logic [5:0] s;
        logic [6:0] tap;
        r = '0;
        s = st;
        for (int i = MAX_W - 1; i >= 0; i--) begin
            if (i < w) begin
                tap     = {word[i], s};
                r.d0[i] = ^(tap & G0);
                r.d1[i] = ^(tap & G1);
                r.d2[i] = ^(tap & G2);
                s       = {word[i], s[5:1]};
            end
        end
        r.st = s;
        return r;
    endfunction

    function automatic logic [5:0] seed_state(input logic [5:0] tail);
        logic [5:0] s;
        for (int j = 0; j < 6; j++) begin
            s[5-j] = tail[j];
        end
        return s;
    endfunction

endpackage

// File: rtl/tbcc_out_fifo.sv
// Show-ahead output buffer holding one {d0,d1,d2} entry per encoded word.
// The head reads as zero while empty so nothing undefined leaks out.
module tbcc_out_fifo
    import tbcc_pkg::*;
#(
    parameter int W     = 24,
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   usedw
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (cnt != FULL);
    assign do_pop  = pop && (cnt != '0);
    assign empty   = (cnt == '0);
    assign usedw   = cnt;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW + 1)'(1);
                2'b01:   cnt <= cnt - (AW + 1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/tbcc_encoder_p.sv
// Block-level K=7 rate-1/3 encoder: pulls words from a show-ahead FIFO,
// encodes one word per cycle and buffers the three coded streams.
module tbcc_encoder_p
    import tbcc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024,
    parameter int LEN_W  = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   data_valid,
    input  logic [DATA_W-1:0]      tail_byte,
    input  logic [LEN_W-1:0]       code_block_length,
    input  logic                   tb_mode,
    input  logic                   blk_empty,
    input  logic [DATA_W-1:0]      blk_data,
    output logic                   blk_data_rdreq,
    output logic [DATA_W-1:0]      q0,
    output logic [DATA_W-1:0]      q1,
    output logic [DATA_W-1:0]      q2,
    output logic                   out_empty,
    output logic [$clog2(DEPTH):0] out_usedw,
    input  logic                   rdreq_subblock,
    output logic                   busy,
    output logic                   computation_done
);

    localparam int UW = $clog2(DEPTH) + 1;
    localparam logic [UW-1:0] FULL = UW'(DEPTH);

    state_t           state_q;
    state_t           state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [5:0]       st_q;
    logic             rdreq;
    enc_t             enc;
    logic [3*DATA_W-1:0] head;
    logic             unused_bits;

    always_comb begin
        enc = encode_word(st_q, MAX_W'(blk_data), DATA_W);
    end

    // Only the low DATA_W bits of each stream and tail bits [5:0] matter.
    assign unused_bits = ^{enc.d0, enc.d1, enc.d2, tail_byte};

    always_comb begin
        state_d          = state_q;
        rdreq            = 1'b0;
        computation_done = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (data_valid) begin
                    state_d = (code_block_length == '0) ? S_DONE : S_ENCODE;
                end
            end
            S_ENCODE: begin
                rdreq = !blk_empty && (out_usedw < FULL) && (cnt_q < len_q);
                if (rdreq && (cnt_q + LEN_W'(1) == len_q)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                computation_done = 1'b1;
                state_d          = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && data_valid) begin
                len_q <= code_block_length;
                cnt_q <= '0;
                st_q  <= tb_mode ? seed_state(tail_byte[5:0]) : 6'd0;
            end else if (rdreq) begin
                cnt_q <= cnt_q + LEN_W'(1);
                st_q  <= enc.st;
            end
        end
    end

    assign blk_data_rdreq = rdreq;
    assign busy           = (state_q != S_IDLE);

    tbcc_out_fifo #(
        .W     (3 * DATA_W),
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rdreq),
        .din   ({enc.d0[DATA_W-1:0], enc.d1[DATA_W-1:0], enc.d2[DATA_W-1:0]}),
        .pop   (rdreq_subblock),
        .dout  (head),
        .empty (out_empty),
        .usedw (out_usedw)
    );

    assign q0 = head[3*DATA_W-1:2*DATA_W];
    assign q1 = head[2*DATA_W-1:DATA_W];
    assign q2 = head[DATA_W-1:0];

endmodule

// File: tb/tb_tbcc_encoder_p.sv
// Directed bench for tbcc_encoder_p (DATA_W=8, DEPTH=4) with an
// upstream FIFO model and a bit-history reference encoder.
module tb_tbcc_encoder_p;

    logic       clk = 1'b0;
    logic       reset;
    logic       data_valid;
    logic [7:0] tail_byte;
    logic [9:0] code_block_length;
    logic       tb_mode;
    logic       blk_empty;
    logic [7:0] blk_data;
    logic       blk_data_rdreq;
    logic [7:0] q0, q1, q2;
    logic       out_empty;
    logic [2:0] out_usedw;
    logic       rdreq_subblock;
    logic       busy;
    logic       computation_done;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] up_mem [64];
    int         up_rd = 0;
    int         up_wr = 0;
    logic       starve = 1'b0;
    int         done_cnt = 0;

    logic [6:1] m_hist;
    logic [7:0] e0 [$];
    logic [7:0] e1 [$];
    logic [7:0] e2 [$];

    tbcc_encoder_p #(
        .DATA_W (8),
        .DEPTH  (4),
        .LEN_W  (10)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .data_valid        (data_valid),
        .tail_byte         (tail_byte),
        .code_block_length (code_block_length),
        .tb_mode           (tb_mode),
        .blk_empty         (blk_empty),
        .blk_data          (blk_data),
        .blk_data_rdreq    (blk_data_rdreq),
        .q0                (q0),
        .q1                (q1),
        .q2                (q2),
        .out_empty         (out_empty),
        .out_usedw         (out_usedw),
        .rdreq_subblock    (rdreq_subblock),
        .busy              (busy),
        .computation_done  (computation_done)
    );

    always #5 clk = ~clk;

    assign blk_empty = (up_rd == up_wr) || starve;
    assign blk_data  = up_mem[up_rd % 64];

    always @(posedge clk) begin
        if (blk_data_rdreq) up_rd <= up_rd + 1;
        if (computation_done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mdl_start(input logic tbm, input logic [7:0] tail);
        m_hist = tbm ? tail[5:0] : 6'd0;
    endtask

    // Reference: direct tap equations on a c_{k-1}..c_{k-6} history.
    task automatic feed(input logic [7:0] w);
        logic [7:0] a, b, c;
        logic [6:1] h;
        logic       x;
        up_mem[up_wr % 64] = w;
        up_wr++;
        h = m_hist;
        for (int i = 7; i >= 0; i--) begin
            x    = w[i];
            a[i] = x ^ h[2] ^ h[3] ^ h[5] ^ h[6];
            b[i] = x ^ h[1] ^ h[2] ^ h[3] ^ h[6];
            c[i] = x ^ h[1] ^ h[2] ^ h[4] ^ h[6];
            h    = {h[5:1], x};
        end
        m_hist = h;
        e0.push_back(a);
        e1.push_back(b);
        e2.push_back(c);
    endtask

    task automatic start(input int len, input logic tbm, input logic [7:0] tail);
        data_valid        = 1'b1;
        code_block_length = 10'(len);
        tb_mode           = tbm;
        tail_byte         = tail;
        tick;
        data_valid        = 1'b0;
    endtask

    task automatic drain(input string tag);
        logic [7:0] a, b, c;
        a = e0.pop_front();
        b = e1.pop_front();
        c = e2.pop_front();
        chk({tag, ".q0"}, 32'(q0), 32'(a));
        chk({tag, ".q1"}, 32'(q1), 32'(b));
        chk({tag, ".q2"}, 32'(q2), 32'(c));
        rdreq_subblock = 1'b1;
        tick;
        rdreq_subblock = 1'b0;
    endtask

    initial begin
        int p0;
        int d0;
        int ep;
        reset             = 1'b1;
        data_valid        = 1'b0;
        tail_byte         = 8'h00;
        code_block_length = 10'd0;
        tb_mode           = 1'b0;
        rdreq_subblock    = 1'b0;
        #12;
        chk("rst.rdreq", 32'(blk_data_rdreq), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(computation_done), 32'd0);
        chk("rst.empty", 32'(out_empty), 32'd1);
        chk("rst.usedw", 32'(out_usedw), 32'd0);
        chk("rst.q0", 32'(q0), 32'd0);
        chk("rst.q1", 32'(q1), 32'd0);
        chk("rst.q2", 32'(q2), 32'd0);
        reset = 1'b0;
        tick;

        // zero-start impulse
        mdl_start(1'b0, 8'h00);
        feed(8'h80);
        start(1, 1'b0, 8'h00);
        chk("zs.rdreq", 32'(blk_data_rdreq), 32'd1);
        tick;
        chk("zs.done", 32'(computation_done), 32'd1);
        chk("zs.busy", 32'(busy), 32'd1);
        chk("zs.empty", 32'(out_empty), 32'd0);
        chk("zs.usedw", 32'(out_usedw), 32'd1);
        chk("zs.q0", 32'(q0), 32'hB6);
        chk("zs.q1", 32'(q1), 32'hF2);
        chk("zs.q2", 32'(q2), 32'hEA);
        tick;
        chk("zs.done_lo", 32'(computation_done), 32'd0);
        chk("zs.idle", 32'(busy), 32'd0);
        chk("zs.ndone", 32'(done_cnt), 32'd1);
        drain("zs");
        chk("zs.empty2", 32'(out_empty), 32'd1);

        // tail-biting impulse
        mdl_start(1'b1, 8'h01);
        feed(8'h01);
        start(1, 1'b1, 8'h01);
        tick;
        chk("tb.q0", 32'(q0), 32'h6D);
        chk("tb.q1", 32'(q1), 32'hE5);
        chk("tb.q2", 32'(q2), 32'hD5);
        tick;
        drain("tb");

        // all ones
        mdl_start(1'b1, 8'hFF);
        feed(8'hFF);
        feed(8'hFF);
        start(2, 1'b1, 8'hFF);
        tick;
        tick;
        chk("ones.done", 32'(computation_done), 32'd1);
        chk("ones.usedw", 32'(out_usedw), 32'd2);
        chk("ones.q0", 32'(q0), 32'hFF);
        chk("ones.q1", 32'(q1), 32'hFF);
        chk("ones.q2", 32'(q2), 32'hFF);
        tick;
        drain("ones0");
        drain("ones1");

        // backpressure: buffer depth 4, block of 6
        p0 = up_rd;
        d0 = done_cnt;
        mdl_start(1'b0, 8'h00);
        feed(8'h80); feed(8'h5A); feed(8'h3C);
        feed(8'hFF); feed(8'h01); feed(8'hA5);
        start(6, 1'b0, 8'h00);
        tick; tick; tick; tick;
        chk("bp.usedw4", 32'(out_usedw), 32'd4);
        chk("bp.stall", 32'(blk_data_rdreq), 32'd0);
        tick; tick;
        chk("bp.pops4", 32'(up_rd - p0), 32'd4);
        chk("bp.busy", 32'(busy), 32'd1);
        chk("bp.nodone", 32'(done_cnt - d0), 32'd0);
        drain("bp0");
        chk("bp.resume", 32'(blk_data_rdreq), 32'd1);
        drain("bp1");
        chk("bp.usedw3", 32'(out_usedw), 32'd3);
        tick;
        chk("bp.done", 32'(computation_done), 32'd1);
        chk("bp.usedw_f", 32'(out_usedw), 32'd4);
        chk("bp.pops6", 32'(up_rd - p0), 32'd6);
        tick;
        for (int i = 0; i < 4; i++) drain("bp_tail");
        chk("bp.ndone", 32'(done_cnt - d0), 32'd1);

        // upstream starvation, tail-biting
        p0 = up_rd;
        mdl_start(1'b1, 8'hC3);
        feed(8'h12); feed(8'h34); feed(8'h56); feed(8'h78);
        start(4, 1'b1, 8'hC3);
        ep = 0;
        for (int i = 0; i < 16 && ep < 4; i++) begin
            starve = i[0];
            #1;
            chk("sv.rdreq", 32'(blk_data_rdreq), 32'(!starve && ep < 4));
            if (!starve) ep++;
            tick;
        end
        starve = 1'b0;
        chk("sv.done", 32'(computation_done), 32'd1);
        chk("sv.pops", 32'(up_rd - p0), 32'd4);
        tick;
        for (int i = 0; i < 4; i++) drain("sv");

        // zero length
        p0 = up_rd;
        d0 = done_cnt;
        start(0, 1'b0, 8'h00);
        chk("z.done", 32'(computation_done), 32'd1);
        chk("z.rdreq", 32'(blk_data_rdreq), 32'd0);
        tick;
        chk("z.idle", 32'(busy), 32'd0);
        chk("z.ndone", 32'(done_cnt - d0), 32'd1);
        chk("z.pops", 32'(up_rd - p0), 32'd0);

        // data_valid while busy is ignored
        mdl_start(1'b0, 8'h00);
        feed(8'hC9); feed(8'h6E);
        start(2, 1'b0, 8'h00);
        data_valid        = 1'b1;
        code_block_length = 10'd0;
        tb_mode           = 1'b1;
        tail_byte         = 8'hFF;
        tick;
        chk("dv.busy", 32'(busy), 32'd1);
        chk("dv.usedw1", 32'(out_usedw), 32'd1);
        tick;
        chk("dv.done", 32'(computation_done), 32'd1);
        data_valid = 1'b0;
        tick;
        chk("dv.idle", 32'(busy), 32'd0);
        chk("dv.usedw2", 32'(out_usedw), 32'd2);
        drain("dv0");
        drain("dv1");

        // asynchronous reset mid-block
        mdl_start(1'b0, 8'h00);
        feed(8'h11); feed(8'h22); feed(8'h33);
        e0.delete(); e1.delete(); e2.delete();
        start(3, 1'b0, 8'h00);
        tick;
        p0 = up_rd;
        #2;
        reset = 1'b1;
        #1;
        chk("ar.busy", 32'(busy), 32'd0);
        chk("ar.rdreq", 32'(blk_data_rdreq), 32'd0);
        chk("ar.done", 32'(computation_done), 32'd0);
        chk("ar.empty", 32'(out_empty), 32'd1);
        chk("ar.usedw", 32'(out_usedw), 32'd0);
        chk("ar.q0", 32'(q0), 32'd0);
        chk("ar.q1", 32'(q1), 32'd0);
        chk("ar.q2", 32'(q2), 32'd0);
        tick;
        chk("ar.nopop", 32'(up_rd - p0), 32'd0);
        reset = 1'b0;
        tick;
        chk("ar.idle", 32'(busy), 32'd0);
        chk("ar.nopop2", 32'(up_rd - p0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
